// File: rtl/sum_xchg_ctrl.sv
// Partial-sum exchange sequencer between core 1 and core 2.
// Moves NTOK tokens each way through the core1->core2 (f12) and core2->core1 (f21) FIFOs
// after a one-cycle start, then pulses done. A watchdog parks the block in an error
// state if no strobe fires for TMO consecutive transfer cycles.
module sum_xchg_ctrl #(
  parameter int unsigned NTOK = 8,
  parameter int unsigned TMO  = 64,
  parameter int unsigned cw   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  input  logic c1_tx_vld,
  input  logic c2_tx_vld,
  input  logic c1_rx_rdy,
  input  logic c2_rx_rdy,
  input  logic f12_full,
  input  logic f12_empty,
  input  logic f21_full,
  input  logic f21_empty,
  output logic f12_wr,
  output logic f12_rd,
  output logic f21_wr,
  output logic f21_rd,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone, StErr} state_e;

  localparam logic [cw-1:0] NtokC   = cw'(NTOK);
  localparam logic [cw:0]   NtokX   = (cw+1)'(NTOK);
  localparam logic [cw-1:0] TmoLast = cw'(TMO - 1);
  localparam logic [cw-1:0] OneC    = cw'(1);

  state_e state_q, state_d;

  // Token counters: writes/reads completed per FIFO.
  logic [cw-1:0] wc12_q, wc12_d;
  logic [cw-1:0] rc12_q, rc12_d;
  logic [cw-1:0] wc21_q, wc21_d;
  logic [cw-1:0] rc21_q, rc21_d;
  logic [cw-1:0] tmo_q, tmo_d;

  // Registered strobes and the full flags they were issued against.
  logic f12_wr_q, f12_wr_d;
  logic f12_rd_q, f12_rd_d;
  logic f21_wr_q, f21_wr_d;
  logic f21_rd_q, f21_rd_d;
  logic f12_full_q, f21_full_q;

  // Counter values after this cycle's strobes have been applied.
  logic [cw-1:0] wc12_nxt, rc12_nxt, wc21_nxt, rc21_nxt;

  // Counts including the strobe currently on the wire, so decisions never overshoot NTOK.
  logic [cw:0] wc12_eff, rc12_eff, wc21_eff, rc21_eff;

  logic f12_pend_full, f21_pend_full;
  logic wr12_ok, rd12_ok, wr21_ok, rd21_ok;
  logic any_strobe;
  logic all_done;
  logic wdog_trip;

  // Per-FIFO strobe qualification and saturating counter updates.
  always_comb begin
    wc12_eff = {1'b0, wc12_q} + {{cw{1'b0}}, f12_wr_q};
    rc12_eff = {1'b0, rc12_q} + {{cw{1'b0}}, f12_rd_q};
    wc21_eff = {1'b0, wc21_q} + {{cw{1'b0}}, f21_wr_q};
    rc21_eff = {1'b0, rc21_q} + {{cw{1'b0}}, f21_rd_q};

    // A write is in flight and the FIFO reported full last cycle: its flag may not yet
    // reflect that write, so hold off stacking another one behind it.
    f12_pend_full = f12_wr_q & f12_full_q;
    f21_pend_full = f21_wr_q & f21_full_q;

    wr12_ok = c1_tx_vld & ~f12_full & (wc12_eff < NtokX) & ~f12_pend_full;
    wr21_ok = c2_tx_vld & ~f21_full & (wc21_eff < NtokX) & ~f21_pend_full;

    // Reads only chase writes that have already landed in the FIFO.
    rd12_ok = c2_rx_rdy & ~f12_empty & (rc12_eff < NtokX) & (rc12_eff < {1'b0, wc12_q});
    rd21_ok = c1_rx_rdy & ~f21_empty & (rc21_eff < NtokX) & (rc21_eff < {1'b0, wc21_q});

    wc12_nxt = (f12_wr_q && (wc12_q != NtokC)) ? wc12_q + OneC : wc12_q;
    rc12_nxt = (f12_rd_q && (rc12_q != NtokC)) ? rc12_q + OneC : rc12_q;
    wc21_nxt = (f21_wr_q && (wc21_q != NtokC)) ? wc21_q + OneC : wc21_q;
    rc21_nxt = (f21_rd_q && (rc21_q != NtokC)) ? rc21_q + OneC : rc21_q;

    any_strobe = f12_wr_q | f12_rd_q | f21_wr_q | f21_rd_q;
    all_done   = (wc12_nxt == NtokC) && (rc12_nxt == NtokC) &&
                 (wc21_nxt == NtokC) && (rc21_nxt == NtokC);
    wdog_trip  = ~any_strobe && (tmo_q == TmoLast);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is honoured only from idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StXfer;
      end
      StXfer: begin
        // The cycle carrying the final strobe completes the exchange.
        if (all_done) begin
          state_d = StDone;
        end else if (wdog_trip) begin
          state_d = StErr;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        if (clear) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Next values for counters, watchdog and registered strobes.
  always_comb begin
    wc12_d   = wc12_q;
    rc12_d   = rc12_q;
    wc21_d   = wc21_q;
    rc21_d   = rc21_q;
    tmo_d    = tmo_q;
    f12_wr_d = 1'b0;
    f12_rd_d = 1'b0;
    f21_wr_d = 1'b0;
    f21_rd_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          wc12_d = '0;
          rc12_d = '0;
          wc21_d = '0;
          rc21_d = '0;
          tmo_d  = '0;
        end
      end
      StXfer: begin
        wc12_d = wc12_nxt;
        rc12_d = rc12_nxt;
        wc21_d = wc21_nxt;
        rc21_d = rc21_nxt;
        tmo_d  = any_strobe ? '0 : tmo_q + OneC;
        // Strobes are only issued for cycles that will still be in transfer.
        if (state_d == StXfer) begin
          f12_wr_d = wr12_ok;
          f12_rd_d = rd12_ok;
          f21_wr_d = wr21_ok;
          f21_rd_d = rd21_ok;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wc12_q     <= '0;
      rc12_q     <= '0;
      wc21_q     <= '0;
      rc21_q     <= '0;
      tmo_q      <= '0;
      f12_wr_q   <= 1'b0;
      f12_rd_q   <= 1'b0;
      f21_wr_q   <= 1'b0;
      f21_rd_q   <= 1'b0;
      f12_full_q <= 1'b0;
      f21_full_q <= 1'b0;
    end else begin
      wc12_q     <= wc12_d;
      rc12_q     <= rc12_d;
      wc21_q     <= wc21_d;
      rc21_q     <= rc21_d;
      tmo_q      <= tmo_d;
      f12_wr_q   <= f12_wr_d;
      f12_rd_q   <= f12_rd_d;
      f21_wr_q   <= f21_wr_d;
      f21_rd_q   <= f21_rd_d;
      f12_full_q <= f12_full;
      f21_full_q <= f21_full;
    end
  end

  // Outputs: status decoded from state, strobes straight from their registers.
  always_comb begin
    busy   = (state_q == StXfer);
    done   = (state_q == StDone);
    err    = (state_q == StErr);
    f12_wr = f12_wr_q;
    f12_rd = f12_rd_q;
    f21_wr = f21_wr_q;
    f21_rd = f21_rd_q;
  end

endmodule

// File: doc/sum_xchg_ctrl.md
Name: sum_xchg_ctrl

Overview:
Sequences the partial-sum exchange between core 1 and core 2 through the two inter-core FIFOs (core1→core2 and core2→core1). On a start pulse it moves NTOK sum tokens in each direction. It drives each FIFO's write and read strobes from core readiness and FIFO full/empty flags, and replaces the hand-built inst[20]/inst[21]/inst[42]/inst[43] exchange bits with a single start/done handshake. A watchdog flags a stalled exchange.

Parameters:
NTOK, 8, sum tokens to transfer per direction per exchange (1..255)
TMO, 64, idle cycles without any strobe before error (≥2)
cw, 8, counter width; must hold NTOK and TMO

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin an exchange
clear  in  1  leaves ERR state
c1_tx_vld  in  1  core 1 has a sum_out token ready
c2_tx_vld  in  1  core 2 has a sum_out token ready
c1_rx_rdy  in  1  core 1 can accept a sum_in token
c2_rx_rdy  in  1  core 2 can accept a sum_in token
f12_full  in  1  core1→core2 FIFO full
f12_empty  in  1  core1→core2 FIFO empty
f21_full  in  1  core2→core1 FIFO full
f21_empty  in  1  core2→core1 FIFO empty
f12_wr  out  1  write strobe, FIFO 1→2; also the tx ack to core 1
f12_rd  out  1  read strobe, FIFO 1→2; also the load strobe to core 2
f21_wr  out  1  write strobe, FIFO 2→1; also the tx ack to core 2
f21_rd  out  1  read strobe, FIFO 2→1; also the load strobe to core 1
busy  out  1  exchange in progress
done  out  1  one-cycle pulse when the exchange completes
err  out  1  watchdog tripped; held until clear or reset

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high and is sampled on the rising edge of clk.
- On reset:
  - all outputs are 0.
  - state = IDLE.
  - counters wc12, wc21, rc12, rc21 and tmo_cnt are 0.
  - Reset asserted mid-exchange aborts it the next edge. No done or err is produced.
- States:
  - IDLE: on start=1, clear all counters and go to XFER (busy=1 from the next cycle). start is ignored in every other state.
  - XFER: all four strobes are registered and evaluated independently each cycle, as below. When all four counters equal NTOK, go to DONE. The cycle of the last strobe counts.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start arriving in DONE is ignored.
  - ERR: err=1, busy=0, all strobes 0. clear=1 returns to IDLE. reset also returns to IDLE.
- Strobe rules in XFER. Strobes are registered outputs, so the decision uses flags sampled on cycle t and the strobe is asserted in cycle t+1.
  - f12_wr = c1_tx_vld & !f12_full & (wc12 < NTOK) & !f12_wr_pending_full. The last term is the occupancy guard: with registered strobes, the implementation never asserts wr on two consecutive cycles unless full is known clear for both.
  - f12_rd = c2_rx_rdy & !f12_empty & (rc12 < NTOK) & (rc12 < wc12).
  - f21_wr and f21_rd are symmetric.
- Each counter increments in the cycle its strobe is high and saturates at NTOK. No strobe is ever issued past NTOK.
- A simultaneous write and read on the same FIFO in one cycle is allowed.
- All four strobes may be high in the same cycle.
- Watchdog:
  - tmo_cnt clears in any XFER cycle with at least one strobe high, and increments otherwise.
  - When tmo_cnt reaches TMO-1 with no strobe, go to ERR next edge.
  - Not active outside XFER.
- The total exchange latency is ≥ NTOK+2 cycles from start to done when all inputs stay ready.

Test Plan:
1. All tx_vld and rx_rdy held 1, FIFOs never full, empty following the model. reset, then start → exactly 8 pulses on each of the four strobes, done pulses once, busy is high from cycle 1 until done, done arrives by cycle ≤ 12.
2. Hold c2_rx_rdy=0 for 20 cycles mid-exchange → f12_rd stalls while the other strobes continue. rc12 resumes after release. done occurs and err stays 0.
3. Hold f12_full=1 for the whole exchange with TMO=64 → f12_wr never asserts. After 64 cycles with no strobe at all, err=1 and busy=0. Pulse clear → IDLE. A new start then succeeds.
4. Assert start again while busy=1 → ignored, with no counter reset. Total strobes are still exactly 8 per direction.
5. Assert reset at cycle 5 of XFER → all outputs 0 on the next edge, no done. A following start completes 8 full tokens per direction.
6. NTOK=1 → exactly one pulse on each strobe. The wr and rd on the same FIFO occur in separate cycles because of rc<wc. done is emitted one cycle after the last rd.
